ni_pkt_enc: RTL and testbench
=============================

// Module: ni_pkt_enc
// PURPOSE
//  Network-interface injection encoder for the node-table-based mesh: packs a core request
//  (unicast node id or multicast destination bitmask plus payload words) into 66-bit flits
//  in the same header layout that the router's route decoder parses (UM_TYPE, DST, MDST fields).
//  Sits between the local core and the router's local input port.
//  Credit-based flow control toward the router.
// PARAMETERS
//  MY_X     0  X coordinate of this node
//  MY_Y     0  Y coordinate of this node
//  ARRAY_W  4  mesh width; MY_ID = MY_Y*ARRAY_W + MY_X
//  CREDITS  4  router local-port input buffer depth (flits); credit counter reset value
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid&&req_ready
//  req_um     in   1   1=multicast, 0=unicast
//  req_dst0   in   11  unicast destination id (`DST field)
//  req_dst1   in   56  multicast destination bitmask, bit i = node i (`MDST field)
//  req_len    in   4   number of payload flits, 0..15
//  pay_valid  in   1   payload word present
//  pay_ready  out  1   payload word consumed when pay_valid&&pay_ready
//  pay_data   in   64  payload word
//  out_valid  out  1   flit valid toward router
//  out_flit   out  66  flit {ftype[65:64], body[63:0]}
//  credit_in  in   1   one router buffer slot freed this cycle
//  cred_err   out  1   sticky: credit_in received with counter already at CREDITS
// BEHAVIOUR
//  - Reset: state=IDLE, credit=CREDITS, req_ready=0 (1 from next cycle), pay_ready=0,
//    out_valid=0, out_flit=0, cred_err=0. Reset mid-packet abandons the packet; no tail sent.
//  - ftype: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEADTAIL (req_len==0).
//  - Head flit: [63]=req_um; unicast: [62:52]=req_dst0, [51:0]=0;
//    multicast: [62:7]=req_dst1 & ~(1<<MY_ID), [6:0]=0. Body/tail flits: [63:0]=pay_data.
//  - Self-delivery is not injected: unicast req_dst0==MY_ID, or multicast mask zero after
//    clearing bit MY_ID -> request accepted, no flits, stays IDLE; payload words are NOT consumed.
//  - FSM: IDLE --accept--> HEAD --flit sent--> BODY (len>0) | IDLE (len==0);
//    BODY: send one flit per pay handshake; last word (count==len) sent as TAIL, then IDLE.
//  - req_ready=1 only in IDLE. Request fields latched on accept.
//  - Send condition: credit>0 (and in BODY, pay_valid). pay_ready = (state==BODY) && credit>0.
//  - Outputs registered: flit appears on out_valid/out_flit the cycle after its send condition;
//    out_valid is a single-cycle pulse per flit. Accept at cycle N -> head at N+2 earliest.
//  - Credit: -1 per flit sent, +1 per credit_in; both in same cycle -> unchanged.
//    credit_in at CREDITS -> saturate, set cred_err. Never sends with credit==0.
//  - Back-to-back packets: next request accepted the cycle after IDLE is re-entered.
// STRUCTURE
//  - define.h: FT_HEAD/FT_BODY/FT_TAIL/FT_HEADTAIL, FSM state codes; reuse existing
//    `UM_TYPE, `DST_MSB/`DST_LSB, `MDST_MSB/`MDST_LSB, `DATAW_P1.
//  - Sub-module ni_credit_cnt (CREDITS): inc, dec, cnt, nonzero, err.
//  - FSM, header build and payload counter in ni_pkt_enc.
// TESTING
//  1 MY=(0,0), unicast dst0=5, len=2, credits free -> HEAD flit {01,0,11'd5,52'b0}, BODY d0, TAIL d1; 3 pulses.
//  2 MY=(0,0), multicast mask ...0001_0001_0001 (0,4,8), len=0 -> one HEADTAIL, [62:7]=...0001_0001_0000.
//  3 Unicast dst0=0 at MY=(0,0) or multicast mask=1 -> req accepted, no out_valid, pay_ready stays 0.
//  4 CREDITS=4, no credit_in, len=7 -> exactly 4 flits then stall; one credit_in -> exactly one more flit.
//  5 credit_in and flit send same cycle at credit=1 -> credit stays 1; credit_in at 4 -> cred_err=1, sticky.
//  6 rst asserted mid-BODY -> next cycle out_valid=0, IDLE, credit=4; new packet starts with HEAD.

Source files
------------

// File: rtl/ni_pkt_enc_pkg.sv
// Shared definitions for the NI injection encoder: flit types,
// header field positions (router route-decoder layout), FSM states.
package ni_pkt_enc_pkg;

    localparam int DATAW_P1 = 66;
    localparam int UM_TYPE  = 63;
    localparam int DST_MSB  = 62;
    localparam int DST_LSB  = 52;
    localparam int MDST_MSB = 62;
    localparam int MDST_LSB = 7;
    localparam int DST_W    = DST_MSB - DST_LSB + 1;
    localparam int MDST_W   = MDST_MSB - MDST_LSB + 1;

    localparam logic [1:0] FT_HEAD     = 2'b01;
    localparam logic [1:0] FT_BODY     = 2'b00;
    localparam logic [1:0] FT_TAIL     = 2'b10;
    localparam logic [1:0] FT_HEADTAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_e;

    function automatic logic [63:0] build_head(
        input logic              um,
        input logic [DST_W-1:0]  dst0,
        input logic [MDST_W-1:0] mask
    );
        logic [63:0] h;
        h = '0;
        h[UM_TYPE] = um;
        if (um)
            h[MDST_MSB:MDST_LSB] = mask;
        else
            h[DST_MSB:DST_LSB] = dst0;
        return h;
    endfunction

endpackage

// File: rtl/ni_credit_cnt.sv
// Credit counter toward the router local input port.
// Ports: inc (credit returned), dec (flit sent), cnt, nonzero, err (sticky overflow).
module ni_credit_cnt
    import ni_pkt_enc_pkg::*;
#(
    parameter int   CREDITS = 4,
    localparam int  CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          nonzero,
    output logic          err
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        // A returned credit while already full means the router
        // freed a slot we never filled.
        if (inc && cnt_q == CW'(CREDITS))
            err_d = 1'b1;
        if (inc && !dec) begin
            if (cnt_q != CW'(CREDITS))
                cnt_d = cnt_q + CW'(1);
        end else if (dec && !inc) begin
            if (cnt_q != '0)
                cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(CREDITS);
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt     = cnt_q;
    assign nonzero = (cnt_q != '0);
    assign err     = err_q;

endmodule

// File: rtl/ni_pkt_enc.sv
// NI injection encoder: packs core requests into 66-bit head/body/tail flits.
// Ports: req_* request, pay_* payload stream, out_* flit to router, credit_in/cred_err.
module ni_pkt_enc
    import ni_pkt_enc_pkg::*;
#(
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0,
    parameter int ARRAY_W = 4,
    parameter int CREDITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_um,
    input  logic [DST_W-1:0]    req_dst0,
    input  logic [MDST_W-1:0]   req_dst1,
    input  logic [3:0]          req_len,
    input  logic                pay_valid,
    output logic                pay_ready,
    input  logic [63:0]         pay_data,
    output logic                out_valid,
    output logic [DATAW_P1-1:0] out_flit,
    input  logic                credit_in,
    output logic                cred_err
);

    localparam int MY_ID = MY_Y * ARRAY_W + MY_X;
    localparam int CW    = $clog2(CREDITS + 1);

    state_e              state_q, state_d;
    logic [63:0]         hdr_q, hdr_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATAW_P1-1:0] out_flit_q, out_flit_d;

    logic                send;
    logic [CW-1:0]       cr_cnt;
    logic                cr_nz;
    logic [MDST_W-1:0]   mask;
    logic                self_dst;

    ni_credit_cnt #(.CREDITS(CREDITS)) u_cred (
        .clk     (clk),
        .rst     (rst),
        .inc     (credit_in),
        .dec     (send),
        .cnt     (cr_cnt),
        .nonzero (cr_nz),
        .err     (cred_err)
    );

    // Own node never appears in an injected multicast mask.
    assign mask     = req_dst1 & ~(MDST_W'(1) << MY_ID);
    assign self_dst = req_um ? (mask == '0)
                             : (req_dst0 == DST_W'(MY_ID));

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign pay_ready = (state_q == ST_BODY) && cr_nz && !rst;

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_flit_d  = out_flit_q;
        send        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Self-addressed requests are swallowed: no flits,
                // payload left untouched.
                if (req_valid && req_ready && !self_dst) begin
                    state_d = ST_HEAD;
                    hdr_d   = build_head(req_um, req_dst0, mask);
                    len_d   = req_len;
                    cnt_d   = 4'd1;
                end
            end
            ST_HEAD: begin
                if (cr_cnt != '0) begin
                    send        = 1'b1;
                    out_valid_d = 1'b1;
                    if (len_q == 4'd0) begin
                        out_flit_d = {FT_HEADTAIL, hdr_q};
                        state_d    = ST_IDLE;
                    end else begin
                        out_flit_d = {FT_HEAD, hdr_q};
                        state_d    = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (pay_valid && pay_ready) begin
                    send        = 1'b1;
                    out_valid_d = 1'b1;
                    if (cnt_q == len_q) begin
                        out_flit_d = {FT_TAIL, pay_data};
                        state_d    = ST_IDLE;
                    end else begin
                        out_flit_d = {FT_BODY, pay_data};
                        cnt_d      = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;

endmodule

// File: tb/tb_ni_pkt_enc.sv
// Directed bench for ni_pkt_enc at node (0,0), CREDITS=4.
// Flits are captured on the falling edge and checked against hand-built values.
module tb_ni_pkt_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_um;
    logic [10:0] req_dst0;
    logic [55:0] req_dst1;
    logic [3:0]  req_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [63:0] pay_data;
    logic        out_valid;
    logic [65:0] out_flit;
    logic        credit_in;
    logic        cred_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [65:0] flits[$];
    int          pay_seen = 0;

    always #5 clk = ~clk;

    ni_pkt_enc #(
        .MY_X(0), .MY_Y(0), .ARRAY_W(4), .CREDITS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_um    (req_um),
        .req_dst0  (req_dst0),
        .req_dst1  (req_dst1),
        .req_len   (req_len),
        .pay_valid (pay_valid),
        .pay_ready (pay_ready),
        .pay_data  (pay_data),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .credit_in (credit_in),
        .cred_err  (cred_err)
    );

    always @(negedge clk) begin
        if (out_valid)
            flits.push_back(out_flit);
        if (pay_ready)
            pay_seen++;
    end

    task automatic chk(input string tag, input logic [65:0] obs,
                       input logic [65:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic um, input logic [10:0] d0,
                          input logic [55:0] d1, input logic [3:0] len);
        int t;
        t = 0;
        while (!req_ready && t < 30) begin
            step(1);
            t++;
        end
        chk("req_ready_wait", 66'(req_ready), 66'd1);
        req_valid = 1'b1;
        req_um    = um;
        req_dst0  = d0;
        req_dst1  = d1;
        req_len   = len;
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic give_credit(input int n);
        repeat (n) begin
            credit_in = 1'b1;
            step(1);
        end
        credit_in = 1'b0;
    endtask

    initial begin
        int base;
        int p0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_um    = 1'b0;
        req_dst0  = '0;
        req_dst1  = '0;
        req_len   = '0;
        pay_valid = 1'b0;
        pay_data  = '0;
        credit_in = 1'b0;

        // reset state
        step(2);
        chk("rst_req_ready", 66'(req_ready), 66'd0);
        chk("rst_pay_ready", 66'(pay_ready), 66'd0);
        chk("rst_out_valid", 66'(out_valid), 66'd0);
        chk("rst_out_flit", out_flit, 66'd0);
        chk("rst_cred_err", 66'(cred_err), 66'd0);
        rst = 1'b0;
        step(1);
        chk("post_rst_req_ready", 66'(req_ready), 66'd1);

        // 1: unicast dst 5, two payload words
        base = flits.size();
        do_req(1'b0, 11'd5, 56'd0, 4'd2);
        pay_valid = 1'b1;
        pay_data  = 64'hA0;
        step(1);
        chk("t1_pay_ready", 66'(pay_ready), 66'd1);
        step(1);
        pay_data = 64'hA1;
        step(1);
        pay_valid = 1'b0;
        step(4);
        chk("t1_nflits", 66'(flits.size() - base), 66'd3);
        if (flits.size() - base == 3) begin
            chk("t1_head", flits[base], {2'b01, 1'b0, 11'd5, 52'd0});
            chk("t1_body", flits[base+1], {2'b00, 64'hA0});
            chk("t1_tail", flits[base+2], {2'b10, 64'hA1});
        end
        chk("t1_idle", 66'(req_ready), 66'd1);
        give_credit(3);

        // 2: multicast nodes 0,4,8, no payload
        base = flits.size();
        p0   = pay_seen;
        do_req(1'b1, 11'd0, 56'h111, 4'd0);
        step(5);
        chk("t2_nflits", 66'(flits.size() - base), 66'd1);
        if (flits.size() - base == 1)
            chk("t2_headtail", flits[base],
                {2'b11, 1'b1, 56'h110, 7'd0});
        chk("t2_no_pay", 66'(pay_seen - p0), 66'd0);
        give_credit(1);

        // 3: self-addressed requests are dropped
        base      = flits.size();
        p0        = pay_seen;
        pay_valid = 1'b1;
        pay_data  = 64'hDEAD;
        do_req(1'b0, 11'd0, 56'd0, 4'd3);
        step(1);
        chk("t3u_ready", 66'(req_ready), 66'd1);
        do_req(1'b1, 11'd0, 56'h1, 4'd2);
        step(5);
        chk("t3_nflits", 66'(flits.size() - base), 66'd0);
        chk("t3_no_pay", 66'(pay_seen - p0), 66'd0);
        chk("t3m_ready", 66'(req_ready), 66'd1);

        // 4: credit stall with len 7
        base     = flits.size();
        pay_data = 64'hB0;
        do_req(1'b0, 11'd2, 56'd0, 4'd7);
        step(20);
        chk("t4_stall4", 66'(flits.size() - base), 66'd4);
        chk("t4_pay_blocked", 66'(pay_ready), 66'd0);
        give_credit(1);
        step(10);
        chk("t4_one_more", 66'(flits.size() - base), 66'd5);
        give_credit(3);
        step(10);
        chk("t4_total", 66'(flits.size() - base), 66'd8);
        if (flits.size() - base == 8)
            chk("t4_tail", 66'(flits[base+7][65:64]), 66'(2'b10));
        give_credit(4);
        chk("t4_no_err", 66'(cred_err), 66'd0);

        // 5: simultaneous credit return and send at credit 1
        do_req(1'b0, 11'd3, 56'd0, 4'd2);
        step(10);
        base = flits.size();
        do_req(1'b0, 11'd6, 56'd0, 4'd1);
        credit_in = 1'b1;
        step(1);
        credit_in = 1'b0;
        step(10);
        chk("t5_nflits", 66'(flits.size() - base), 66'd2);
        if (flits.size() - base == 2) begin
            chk("t5_head", flits[base], {2'b01, 1'b0, 11'd6, 52'd0});
            chk("t5_tail_type", 66'(flits[base+1][65:64]), 66'(2'b10));
        end
        give_credit(4);
        chk("t5_err_clear", 66'(cred_err), 66'd0);
        give_credit(1);
        chk("t5_err_set", 66'(cred_err), 66'd1);
        step(3);
        chk("t5_err_sticky", 66'(cred_err), 66'd1);

        // 6: reset mid-packet
        do_req(1'b0, 11'd3, 56'd0, 4'd5);
        step(3);
        rst = 1'b1;
        step(1);
        chk("t6_out_valid", 66'(out_valid), 66'd0);
        chk("t6_out_flit", out_flit, 66'd0);
        chk("t6_req_ready_rst", 66'(req_ready), 66'd0);
        chk("t6_err_cleared", 66'(cred_err), 66'd0);
        rst = 1'b0;
        step(1);
        chk("t6_idle", 66'(req_ready), 66'd1);
        base = flits.size();
        do_req(1'b0, 11'd9, 56'd0, 4'd7);
        step(20);
        chk("t6_credit4", 66'(flits.size() - base), 66'd4);
        if (flits.size() - base >= 1)
            chk("t6_head", flits[base], {2'b01, 1'b0, 11'd9, 52'd0});

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
